// File: rtl/clk_ena_sequencer.sv
`default_nettype none
// clk_ena_sequencer: synchronises PLL lock, holds the core in reset for RST_DELAY cycles,
// then drives NUM_CH divided clock-enables with hold/single-step debug control.
module clk_ena_sequencer #(
    parameter int NUM_CH    = 2,
    parameter int DIV_W     = 4,
    parameter int RST_DELAY = 256
) (
    input  logic                    I_CLK,
    input  logic                    I_RESET_N,
    input  logic                    I_LOCKED,
    input  logic [NUM_CH*DIV_W-1:0] I_DIV,
    input  logic [NUM_CH*DIV_W-1:0] I_PHASE,
    input  logic                    I_HOLD,
    input  logic                    I_STEP,
    output logic                    O_RESET,
    output logic [NUM_CH-1:0]       O_ENA,
    output logic                    O_ALIGN,
    output logic                    O_READY
);
    localparam int               DLY_W    = (RST_DELAY > 1) ? $clog2(RST_DELAY) : 1;
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(RST_DELAY - 1);

    localparam logic [1:0] WAIT_LOCK = 2'd0;
    localparam logic [1:0] DELAY     = 2'd1;
    localparam logic [1:0] RUN       = 2'd2;

    logic                         lock_meta;
    logic                         lock_s;
    logic [1:0]                   state;
    logic [1:0]                   next_state;
    logic [DLY_W-1:0]             dly_cnt;
    logic [DLY_W-1:0]             dly_cnt_d;
    logic [NUM_CH-1:0][DIV_W-1:0] cnt;
    logic [NUM_CH-1:0][DIV_W-1:0] cnt_d;
    logic [NUM_CH-1:0][DIV_W-1:0] div_sh;
    logic [NUM_CH-1:0][DIV_W-1:0] phase_sh;
    logic [NUM_CH-1:0]            ena_d;
    logic                         align_d;
    logic                         adv;
    logic                         latch;

    assign adv   = !I_HOLD | I_STEP;
    assign latch = (state == DELAY) && (next_state == RUN);

    always_ff @(posedge I_CLK) begin
        if (!I_RESET_N) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
            state     <= WAIT_LOCK;
            dly_cnt   <= '0;
            cnt       <= '0;
            div_sh    <= '0;
            phase_sh  <= '0;
            O_RESET   <= 1'b1;
            O_ENA     <= '0;
            O_ALIGN   <= 1'b0;
            O_READY   <= 1'b0;
        end else begin
            lock_meta <= I_LOCKED;
            lock_s    <= lock_meta;
            state     <= next_state;
            dly_cnt   <= dly_cnt_d;
            cnt       <= cnt_d;
            // Divide/phase are frozen for the whole RUN stay
            if (latch) begin
                div_sh   <= I_DIV;
                phase_sh <= I_PHASE;
            end
            O_ENA     <= ena_d;
            O_ALIGN   <= align_d;
            O_RESET   <= (next_state != RUN);
            O_READY   <= (next_state == RUN);
        end
    end

    always_comb begin
        next_state = state;
        dly_cnt_d  = '0;
        case (state)
            WAIT_LOCK: next_state = DELAY;
            DELAY: begin
                dly_cnt_d = dly_cnt + DLY_W'(1);
                if (dly_cnt == DLY_LAST) begin
                    next_state = RUN;
                end
            end
            RUN:     next_state = RUN;
            default: next_state = WAIT_LOCK;
        endcase
        if (!lock_s) begin
            next_state = WAIT_LOCK;
            dly_cnt_d  = '0;
        end
    end

    always_comb begin
        cnt_d   = cnt;
        ena_d   = '0;
        align_d = 1'b0;
        if ((state == RUN) && (next_state == RUN)) begin
            if (adv) begin
                align_d = 1'b1;
                for (int i = 0; i < NUM_CH; i++) begin
                    ena_d[i] = (cnt[i] == phase_sh[i]);
                    cnt_d[i] = (cnt[i] == div_sh[i]) ? '0 : cnt[i] + DIV_W'(1);
                    if (cnt[i] != '0) begin
                        align_d = 1'b0;
                    end
                end
            end
        end else begin
            cnt_d = '0;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_clk_ena_sequencer.sv
`default_nettype none
// tb_clk_ena_sequencer: directed self-checking bench for clk_ena_sequencer (NUM_CH=2, RST_DELAY=256).
module tb_clk_ena_sequencer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       locked;
    logic       hold;
    logic       step;
    logic [7:0] div;
    logic [7:0] phase;
    logic       o_reset;
    logic [1:0] ena;
    logic       align;
    logic       ready;

    int checks = 0;
    int errors = 0;

    logic [1:0] pac_ena   [8] = '{2'b00, 2'b11, 2'b00, 2'b01, 2'b00, 2'b11, 2'b00, 2'b01};
    logic       pac_align [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [1:0] p6_ena    [8] = '{2'b00, 2'b11, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b11};
    logic       p6_align  [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    always #5 clk = ~clk;

    clk_ena_sequencer #(
        .NUM_CH    (2),
        .DIV_W     (4),
        .RST_DELAY (256)
    ) dut (
        .I_CLK     (clk),
        .I_RESET_N (rst_n),
        .I_LOCKED  (locked),
        .I_DIV     (div),
        .I_PHASE   (phase),
        .I_HOLD    (hold),
        .I_STEP    (step),
        .O_RESET   (o_reset),
        .O_ENA     (ena),
        .O_ALIGN   (align),
        .O_READY   (ready)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_reset"}, 32'(o_reset), 32'd1);
        check({tag, "_ena"},   32'(ena),     32'd0);
        check({tag, "_align"}, 32'(align),   32'd0);
        check({tag, "_ready"}, 32'(ready),   32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int c0;
        int c1;
        rst_n  = 1'b0;
        locked = 1'b1;
        hold   = 1'b0;
        step   = 1'b0;
        div    = {4'd3, 4'd1};
        phase  = {4'd1, 4'd1};
        tick(2);
        check_reset("por");

        // Pacman mode: reset falls on edge 259 after release
        rst_n = 1'b1;
        tick(258);
        check("pac_edge258_reset", 32'(o_reset), 32'd1);
        check("pac_edge258_ready", 32'(ready),   32'd0);
        tick(1);
        check("pac_edge259_reset", 32'(o_reset), 32'd0);
        check("pac_edge259_ready", 32'(ready),   32'd1);
        check("pac_edge259_ena",   32'(ena),     32'd0);
        for (int k = 0; k < 8; k++) begin
            tick(1);
            check($sformatf("pac_ena_%0d", k),   32'(ena),   32'(pac_ena[k]));
            check($sformatf("pac_align_%0d", k), 32'(align), 32'(pac_align[k]));
        end

        // Changing I_DIV in RUN has no effect
        div = {4'd5, 4'd1};
        for (int k = 0; k < 8; k++) begin
            tick(1);
            check($sformatf("shadow_ena_%0d", k),   32'(ena),   32'(pac_ena[k]));
            check($sformatf("shadow_align_%0d", k), 32'(align), 32'(pac_align[k]));
        end

        // One-cycle lock loss
        locked = 1'b0;
        tick(1);
        locked = 1'b1;
        check("loss_e1_reset", 32'(o_reset), 32'd0);
        tick(1);
        check("loss_e2_reset", 32'(o_reset), 32'd0);
        tick(1);
        check("loss_e3_reset", 32'(o_reset), 32'd1);
        check("loss_e3_ena",   32'(ena),     32'd0);
        check("loss_e3_ready", 32'(ready),   32'd0);
        tick(256);
        check("relock_258_reset", 32'(o_reset), 32'd1);
        tick(1);
        check("relock_259_reset", 32'(o_reset), 32'd0);
        check("relock_259_ready", 32'(ready),   32'd1);
        for (int k = 0; k < 8; k++) begin
            tick(1);
            check($sformatf("p6_ena_%0d", k),   32'(ena),   32'(p6_ena[k]));
            check($sformatf("p6_align_%0d", k), 32'(align), 32'(p6_align[k]));
        end

        // Reset mid-RUN, then again during DELAY
        div   = {4'd3, 4'd2};
        phase = {4'd5, 4'd2};
        hold  = 1'b1;
        rst_n = 1'b0;
        tick(1);
        check_reset("run_rst");
        rst_n = 1'b1;
        tick(100);
        check("dly_mid_reset", 32'(o_reset), 32'd1);
        rst_n = 1'b0;
        tick(1);
        check_reset("dly_rst");
        rst_n = 1'b1;
        tick(258);
        check("dly_restart_258", 32'(o_reset), 32'd1);
        tick(1);
        check("dly_restart_259", 32'(o_reset), 32'd0);

        // Hold and single-step
        for (int k = 0; k < 3; k++) begin
            tick(1);
            check($sformatf("hold_ena_%0d", k),   32'(ena),   32'd0);
            check($sformatf("hold_align_%0d", k), 32'(align), 32'd0);
        end
        step = 1'b1;
        tick(1);
        step = 1'b0;
        check("step1_ena",   32'(ena),   32'd0);
        check("step1_align", 32'(align), 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick(1);
            check($sformatf("gap1_ena_%0d", k),   32'(ena),   32'd0);
            check($sformatf("gap1_align_%0d", k), 32'(align), 32'd0);
        end
        step = 1'b1;
        tick(1);
        step = 1'b0;
        check("step2_ena", 32'(ena), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick(1);
            check($sformatf("gap2_ena_%0d", k), 32'(ena), 32'd0);
        end
        step = 1'b1;
        tick(1);
        step = 1'b0;
        check("step3_ena", 32'(ena), 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick(1);
            check($sformatf("gap3_ena_%0d", k), 32'(ena), 32'd0);
        end

        // Step held high while holding advances every cycle
        step = 1'b1;
        tick(1);
        check("stephold_a", 32'(ena), 32'd0);
        tick(1);
        check("stephold_b", 32'(ena), 32'd0);
        tick(1);
        check("stephold_c", 32'(ena), 32'd1);

        // Free run with step still high; ch1 phase > div never fires
        hold = 1'b0;
        c0   = 0;
        c1   = 0;
        for (int k = 0; k < 99; k++) begin
            tick(1);
            c0 += int'(ena[0]);
            c1 += int'(ena[1]);
        end
        step = 1'b0;
        check("div2_pulse_count",    32'(c0), 32'd33);
        check("phase_gt_div_pulses", 32'(c1), 32'd0);

        // DIV=0, PHASE=0 after a relock
        div    = {4'd1, 4'd0};
        phase  = {4'd0, 4'd0};
        locked = 1'b0;
        tick(1);
        locked = 1'b1;
        tick(2);
        check("div0_drop_reset", 32'(o_reset), 32'd1);
        n = 0;
        while (o_reset && n < 400) begin
            tick(1);
            n++;
        end
        check("div0_relock_timeout", 32'(o_reset), 32'd0);
        check("div0_first_cycle",    32'(ena[0]),  32'd0);
        c0 = 0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            c0 += int'(ena[0]);
        end
        check("div0_const_high", 32'(c0), 32'd10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/clk_ena_sequencer.md
# clk_ena_sequencer

Parametrised clock-enable and reset sequencer for single-clock core designs. It synchronises a PLL lock flag and holds the core in reset for a fixed delay after lock. It then releases reset aligned to NUM_CH programmable clock-enable channels, each with its own divide and phase. A hold/single-step mode freezes all enables for debug. It sits in the top level between the PLL and the game core, driving the core's reset and enable inputs.

## Interface
- NUM_CH, 2, number of enable channels (1..8)
- DIV_W, 4, width of each per-channel divide/phase field
- RST_DELAY, 256, cycles from synchronised lock to reset release (>= 1)

- I_CLK  in  1  core clock; all logic on rising edge
- I_RESET_N  in  1  synchronous, active-low reset
- I_LOCKED  in  1  PLL lock, asynchronous to I_CLK
- I_DIV  in  NUM_CH*DIV_W  per-channel period minus one; channel i at [i*DIV_W +: DIV_W]
- I_PHASE  in  NUM_CH*DIV_W  per-channel count value at which the enable fires
- I_HOLD  in  1  freeze all enable counters while high
- I_STEP  in  1  single-cycle advance while I_HOLD is high
- O_RESET  out  1  active-high core reset
- O_ENA  out  NUM_CH  registered clock-enable pulses
- O_ALIGN  out  1  pulse: all channel counters were 0 on an advancing cycle
- O_READY  out  1  high in RUN state

## Operation
- Lock sync: two-flop synchroniser on I_LOCKED gives lock_s. Both flops clear on reset.
- FSM states: WAIT_LOCK, DELAY, RUN. Reset enters WAIT_LOCK.
- WAIT_LOCK -> DELAY when lock_s=1. The delay counter clears to 0.
- DELAY: the delay counter increments each cycle. When it equals RST_DELAY-1 -> RUN.
- Any state with lock_s=0 -> WAIT_LOCK on the next edge, which gives O_RESET=1 and O_ENA=0. This overrides all other transitions.
- On the DELAY->RUN edge:
  - all channel counters load 0;
  - I_DIV and I_PHASE are latched into shadow registers.
- The shadow registers are used for the whole RUN stay. Input changes in RUN have no effect until the next sequence.
- In RUN, an advancing cycle is adv = !I_HOLD | I_STEP. For every channel i on an advancing cycle:
  - O_ENA[i] <= (cnt_i == phase_i);
  - cnt_i <= (cnt_i == div_i) ? 0 : cnt_i+1.
- Non-advancing RUN cycle: O_ENA <= 0, O_ALIGN <= 0, counters hold.
- O_ALIGN <= adv & all cnt_i == 0.
- phase_i > div_i: channel i never asserts. This is legal, not an error.
- div_i = 0: channel asserts on every advancing cycle when phase_i = 0.
- O_RESET <= (next state != RUN). O_READY <= (next state == RUN).
- Outside RUN: O_ENA=0, O_ALIGN=0, counters held at 0.

## Timing
- Reset values: O_RESET=1, O_ENA=0, O_ALIGN=0, O_READY=0, FSM=WAIT_LOCK, delay counter=0, channel counters=0, shadows=0.
- I_LOCKED rise to lock_s: 2 cycles.
- lock_s high to O_RESET fall: RST_DELAY+1 edges. O_READY rises on the same edge.
- The first O_ENA[i] pulse occurs phase_i+1 cycles after O_RESET falls, assuming no hold.
- The first O_ALIGN occurs 1 cycle after O_RESET falls.
- I_LOCKED fall to O_RESET=1: 3 edges (2 sync + 1 register).
- I_STEP while I_HOLD=0: no extra effect.
- I_STEP held high with I_HOLD=1: advances every cycle.
- I_RESET_N low mid-RUN: all outputs take reset values at the next edge. A full lock/delay sequence is required after release.

## Test plan
- Pacman mode: NUM_CH=2, RST_DELAY=256, I_DIV={3,1}, I_PHASE={1,1}, I_LOCKED=1 from reset.
  - O_RESET falls at edge 259 after reset release.
  - O_ENA[0] is high every 2nd cycle, O_ENA[1] every 4th cycle.
  - Both are high on the same cycle 2 cycles after the O_RESET fall.
  - O_ALIGN pulses every 4 cycles.
- Lock loss: drop I_LOCKED for 1 cycle mid-RUN.
  - O_RESET=1 and O_ENA=0 within 3 edges.
  - After relock, O_RESET falls 256+3 cycles after the I_LOCKED rise.
- Hold/step: DIV=2, PHASE=2. Assert I_HOLD, then give 3 single I_STEP pulses 5 cycles apart.
  - Exactly one O_ENA pulse, on the cycle after the 3rd step.
  - No pulses between steps.
- Shadow latch: change I_DIV from 3 to 5 during RUN.
  - Period stays 4.
  - After a lock cycle, period becomes 6.
- Edge cases:
  - PHASE=5, DIV=3: O_ENA never high over 100 cycles.
  - DIV=0, PHASE=0: O_ENA constantly high from the 2nd RUN cycle.
- Sync reset: pulse I_RESET_N low for 1 cycle during DELAY.
  - All outputs at reset values on the next edge.
  - Delay restarts from 0.
